// File: rtl/beta_exe_stage_pkg.sv
// Shared execute-stage definitions: load/store unit states and the memory
// operation encodings produced by the decode stage control word.
package beta_exe_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    // Access size encodings; must track decode's exe_mem_op_size values.
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    // Operation direction encodings (exe_mem_op).
    localparam logic MEM_OP_LOAD  = 1'b0;
    localparam logic MEM_OP_STORE = 1'b1;

endpackage

// File: rtl/beta_lsu_align.sv
// Combinational byte-lane logic for the load/store unit: misalignment check,
// byte-enable and store-data lane replication on the request side, and
// lane extraction plus sign/zero extension on the load-return side.
module beta_lsu_align
    import beta_exe_stage_pkg::*;
(
    input  logic [1:0]  addr_off_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    output logic        misaligned_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_lanes_o,
    input  logic [1:0]  ld_off_i,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [31:0] shifted_s;

    // Request side: decide legality and place store data on its byte lanes.
    always_comb begin
        misaligned_o  = 1'b0;
        be_o          = 4'b0000;
        wdata_lanes_o = wdata_i;
        case (size_i)
            MEM_SIZE_BYTE: begin
                be_o          = 4'b0001 << addr_off_i;
                wdata_lanes_o = {4{wdata_i[7:0]}};
            end
            MEM_SIZE_HALF: begin
                misaligned_o  = addr_off_i[0];
                be_o          = 4'b0011 << addr_off_i;
                wdata_lanes_o = {2{wdata_i[15:0]}};
            end
            MEM_SIZE_WORD: begin
                misaligned_o  = (addr_off_i != 2'b00);
                be_o          = 4'b1111;
                wdata_lanes_o = wdata_i;
            end
            default: begin
                misaligned_o  = 1'b1;
                be_o          = 4'b0000;
                wdata_lanes_o = wdata_i;
            end
        endcase
    end

    assign shifted_s = rdata_i >> {ld_off_i, 3'b000};

    // Load side: pick the addressed lanes and extend to a full word.
    always_comb begin
        ld_data_o = 32'd0;
        case (ld_size_i)
            MEM_SIZE_BYTE: ld_data_o = ld_unsigned_i ? {24'd0, shifted_s[7:0]}
                                                     : {{24{shifted_s[7]}}, shifted_s[7:0]};
            MEM_SIZE_HALF: ld_data_o = ld_unsigned_i ? {16'd0, shifted_s[15:0]}
                                                     : {{16{shifted_s[15]}}, shifted_s[15:0]};
            MEM_SIZE_WORD: ld_data_o = shifted_s;
            default:       ld_data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/beta_lsu.sv
// Execute-stage load/store unit. Accepts one memory operation at a time,
// runs the data-memory req/gnt/rvalid handshake and returns a single
// registered completion pulse. Illegal accesses complete with an error and
// never reach memory.
module beta_lsu
    import beta_exe_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              mem_op_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [DATA_W-1:0] data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [DATA_W-1:0] data_rdata_i
);

    lsu_state_e  state_r;
    logic        ready_r;
    logic [1:0]  off_r;
    logic [1:0]  size_r;
    logic        unsigned_r;

    logic        misaligned_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_lanes_s;
    logic [31:0] ld_data_s;

    beta_lsu_align u_align (
        .addr_off_i    (addr_i[1:0]),
        .size_i        (size_i),
        .wdata_i       (wdata_i),
        .misaligned_o  (misaligned_s),
        .be_o          (be_s),
        .wdata_lanes_o (wdata_lanes_s),
        .ld_off_i      (off_r),
        .ld_size_i     (size_r),
        .ld_unsigned_i (unsigned_r),
        .rdata_i       (data_rdata_i),
        .ld_data_o     (ld_data_s)
    );

    assign req_ready_o = ready_r;

    // Operation sequencer: owns the memory bus outputs and the response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            ready_r      <= 1'b1;
            off_r        <= 2'b00;
            size_r       <= 2'b00;
            unsigned_r   <= 1'b0;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0000;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid_i) begin
                        ready_r <= 1'b0;
                        if (misaligned_s) begin
                            // Fault completes without a bus cycle.
                            state_r      <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
                        end else begin
                            state_r      <= REQ;
                            off_r        <= addr_i[1:0];
                            size_r       <= size_i;
                            unsigned_r   <= unsigned_i;
                            data_req_o   <= 1'b1;
                            data_we_o    <= (mem_op_i == MEM_OP_STORE);
                            data_be_o    <= be_s;
                            data_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                            data_wdata_o <= wdata_lanes_s;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (data_gnt_i) begin
                        data_req_o <= 1'b0;
                        if (data_we_o == MEM_OP_LOAD) begin
                            state_r <= WAIT_R;
                        end else begin
                            state_r      <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b0;
                            resp_rdata_o <= '0;
                        end
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT_R: begin
                    if (data_rvalid_i) begin
                        state_r      <= RESP;
                        resp_valid_o <= 1'b1;
                        resp_err_o   <= 1'b0;
                        resp_rdata_o <= ld_data_s;
                    end else begin
                        state_r <= WAIT_R;
                    end
                end
                RESP: begin
                    state_r      <= IDLE;
                    ready_r      <= 1'b1;
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= '0;
                end
                default: begin
                    state_r      <= IDLE;
                    ready_r      <= 1'b1;
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                    resp_rdata_o <= '0;
                    data_req_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beta_lsu.sv
// Directed bench for beta_lsu with a hand-driven data-memory side.
module tb_beta_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        mem_op;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        data_req;
    logic        data_gnt;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    beta_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .mem_op_i      (mem_op),
        .size_i        (size),
        .unsigned_i    (uns),
        .addr_i        (addr),
        .wdata_i       (wdata),
        .resp_valid_o  (resp_valid),
        .resp_rdata_o  (resp_rdata),
        .resp_err_o    (resp_err),
        .data_req_o    (data_req),
        .data_gnt_i    (data_gnt),
        .data_addr_o   (data_addr),
        .data_we_o     (data_we),
        .data_be_o     (data_be),
        .data_wdata_o  (data_wdata),
        .data_rvalid_i (data_rvalid),
        .data_rdata_i  (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation end to end; cycle 1 is the accept cycle, latency is the
    // cycle number in which resp_valid is seen.
    task automatic run_op(input string tag, input logic op, input logic [1:0] sz,
                          input logic un, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] mem_rd, input int gnt_dly, input int rv_dly,
                          input logic exp_err, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                          input int exp_lat);
        int n;
        logic seen;
        check_eq({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        mem_op = op; size = sz; uns = un; addr = a; wdata = wd;
        req_valid = 1'b1;
        n = 1;
        tick();
        req_valid = 1'b0;
        n = 2;
        if (!exp_err) begin
            for (int k = 0; k <= gnt_dly; k++) begin
                check_eq({tag, "_req"},   {31'd0, data_req}, 32'd1);
                check_eq({tag, "_addr"},  data_addr, {a[31:2], 2'b00});
                check_eq({tag, "_be"},    {28'd0, data_be}, {28'd0, exp_be});
                check_eq({tag, "_we"},    {31'd0, data_we}, {31'd0, op});
                check_eq({tag, "_wdata"}, data_wdata, exp_wd);
                if (k == gnt_dly) data_gnt = 1'b1;
                tick();
                n++;
                data_gnt = 1'b0;
            end
            check_eq({tag, "_req_drop"}, {31'd0, data_req}, 32'd0);
            if (op == 1'b0) begin
                for (int k = 0; k <= rv_dly; k++) begin
                    check_eq({tag, "_early_resp"}, {31'd0, resp_valid}, 32'd0);
                    if (k == rv_dly) begin
                        data_rvalid = 1'b1;
                        data_rdata  = mem_rd;
                    end else begin
                        data_rdata  = ~mem_rd;
                    end
                    tick();
                    n++;
                    data_rvalid = 1'b0;
                end
            end
        end else begin
            check_eq({tag, "_no_req"}, {31'd0, data_req}, 32'd0);
        end
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            if (resp_valid) seen = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        check_eq({tag, "_resp_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check_eq({tag, "_latency"}, n, exp_lat);
            check_eq({tag, "_err"},     {31'd0, resp_err}, {31'd0, exp_err});
            check_eq({tag, "_rdata"},   resp_rdata, exp_rd);
            check_eq({tag, "_busy"},    {31'd0, req_ready}, 32'd0);
            tick();
            check_eq({tag, "_pulse"},   {31'd0, resp_valid}, 32'd0);
            check_eq({tag, "_err_clr"}, {31'd0, resp_err}, 32'd0);
            check_eq({tag, "_rd_clr"},  resp_rdata, 32'd0);
            check_eq({tag, "_ready2"},  {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; mem_op = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'd0; wdata = 32'd0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = 32'd0;
        tick();
        tick();
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_err",   {31'd0, resp_err}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_req",   {31'd0, data_req}, 32'd0);
        check_eq("rst_we",    {31'd0, data_we}, 32'd0);
        check_eq("rst_be",    {28'd0, data_be}, 32'd0);
        check_eq("rst_addr",  data_addr, 32'd0);
        check_eq("rst_wdata", data_wdata, 32'd0);
        rst = 1'b0;
        tick();

        //      tag      op    sz     un    addr          wdata         mem_rd        g  r  err   be       exp_wd        exp_rd        lat
        run_op("sb",     1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0,        0, 0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0,        3);
        run_op("lb",     1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0,        32'h0000_8000, 0, 0, 1'b0, 4'b0010, 32'h0,        32'hFFFF_FF80, 4);
        run_op("lbu",    1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0,        32'h0000_8000, 0, 0, 1'b0, 4'b0010, 32'h0,        32'h0000_0080, 4);
        run_op("lh_dly", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0,        32'h8001_1234, 3, 1, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001, 8);
        run_op("sw_mis", 1'b1, 2'b10, 1'b0, 32'h0000_3002, 32'h1111_2222, 32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0,        2);
        run_op("s_ill",  1'b1, 2'b11, 1'b0, 32'h0000_3000, 32'h1111_2222, 32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0,        2);
        run_op("sh",     1'b1, 2'b01, 1'b0, 32'h0000_4002, 32'h0000_BEEF, 32'h0,        0, 0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0,        3);
        run_op("sw_dly", 1'b1, 2'b10, 1'b0, 32'h0000_5000, 32'h1234_5678, 32'h0,        2, 0, 1'b0, 4'b1111, 32'h1234_5678, 32'h0,        5);
        run_op("lhu",    1'b0, 2'b01, 1'b1, 32'h0000_6000, 32'h0,        32'h1234_F00D, 0, 0, 1'b0, 4'b0011, 32'h0,        32'h0000_F00D, 4);
        run_op("lb3",    1'b0, 2'b00, 1'b0, 32'h0000_6003, 32'h0,        32'h7F00_0000, 0, 0, 1'b0, 4'b1000, 32'h0,        32'h0000_007F, 4);
        run_op("lw",     1'b0, 2'b10, 1'b0, 32'h0000_7004, 32'h0,        32'hDEAD_BEEF, 0, 2, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 6);
        run_op("lh_mis", 1'b0, 2'b01, 1'b0, 32'h0000_7001, 32'h0,        32'h0,        0, 0, 1'b1, 4'b0000, 32'h0,        32'h0,        2);

        // Reset while waiting for load data, then a stale rvalid.
        mem_op = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h0000_2000;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        check_eq("rst_mid_waitr", {31'd0, data_req}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_mid_req",   {31'd0, data_req}, 32'd0);
        check_eq("rst_mid_resp",  {31'd0, resp_valid}, 32'd0);
        data_rvalid = 1'b1;
        data_rdata  = 32'h0000_0055;
        tick();
        data_rvalid = 1'b0;
        check_eq("stale_rv_resp",  {31'd0, resp_valid}, 32'd0);
        check_eq("stale_rv_ready", {31'd0, req_ready}, 32'd1);
        tick();
        check_eq("stale_rv_resp2", {31'd0, resp_valid}, 32'd0);
        run_op("post_rst_lb", 1'b0, 2'b00, 1'b0, 32'h0000_2000, 32'h0, 32'h0000_0081, 0, 0, 1'b0, 4'b0001, 32'h0, 32'hFFFF_FF81, 4);

        // Back-to-back: valid stays high, second op must wait for IDLE.
        mem_op = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h0000_8000; wdata = 32'hCAFE_F00D;
        req_valid = 1'b1;
        check_eq("b2b_ready1", {31'd0, req_ready}, 32'd1);
        tick();
        mem_op = 1'b1; size = 2'b00; addr = 32'h0000_9001; wdata = 32'h0000_003C;
        check_eq("b2b_busy_req",  {31'd0, req_ready}, 32'd0);
        check_eq("b2b_a_addr",    data_addr, 32'h0000_8000);
        check_eq("b2b_a_wdata",   data_wdata, 32'hCAFE_F00D);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        check_eq("b2b_a_resp",    {31'd0, resp_valid}, 32'd1);
        check_eq("b2b_busy_resp", {31'd0, req_ready}, 32'd0);
        check_eq("b2b_no_req_r",  {31'd0, data_req}, 32'd0);
        tick();
        check_eq("b2b_ready2",    {31'd0, req_ready}, 32'd1);
        check_eq("b2b_no_req_i",  {31'd0, data_req}, 32'd0);
        check_eq("b2b_a_clr",     {31'd0, resp_valid}, 32'd0);
        tick();
        req_valid = 1'b0;
        check_eq("b2b_b_req",     {31'd0, data_req}, 32'd1);
        check_eq("b2b_b_addr",    data_addr, 32'h0000_9000);
        check_eq("b2b_b_be",      {28'd0, data_be}, 32'd2);
        check_eq("b2b_b_wdata",   data_wdata, 32'h3C3C_3C3C);
        data_gnt = 1'b1;
        tick();
        data_gnt = 1'b0;
        check_eq("b2b_b_resp",    {31'd0, resp_valid}, 32'd1);
        check_eq("b2b_b_err",     {31'd0, resp_err}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
